// File: rtl/l1_cache_pkg.sv
// Shared types and default geometry for the L1 data cache.
package l1_cache_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int NUM_LINES_DEF   = 16;
  localparam int BLOCK_WORDS_DEF = 16;

  localparam int OFFSET_W = $clog2(BLOCK_WORDS_DEF);
  localparam int INDEX_W  = $clog2(NUM_LINES_DEF);
  localparam int TAG_W    = ADDR_W_DEF - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WTHRU} state_t;

  typedef logic [BLOCK_WORDS_DEF-1:0][DATA_W_DEF-1:0] block_t;

endpackage

// File: rtl/l1_line_store.sv
// Direct-mapped line storage: valid/tag/data, async read by index, one write
// port that installs a block with an optional single-word overlay.
module l1_line_store
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_LINES   = 16,
  parameter int BLOCK_WORDS = 16,
  parameter int IDX_BITS    = INDEX_W,
  parameter int OFF_BITS    = OFFSET_W,
  parameter int TAG_BITS    = TAG_W
)(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [IDX_BITS-1:0]                   rd_idx,
  output logic                                  rd_valid,
  output logic [TAG_BITS-1:0]                   rd_tag,
  output logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] rd_block,
  input  logic                                  wr_en,
  input  logic [IDX_BITS-1:0]                   wr_idx,
  input  logic [TAG_BITS-1:0]                   wr_tag,
  input  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] wr_block,
  input  logic                                  wr_merge,
  input  logic [OFF_BITS-1:0]                   wr_off,
  input  logic [DATA_WIDTH-1:0]                 wr_word
);

  logic [NUM_LINES-1:0]                    valid;
  logic [TAG_BITS-1:0]                     tags [NUM_LINES];
  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]  data [NUM_LINES];
  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]  mix;

  always_comb begin
    mix = wr_block;
    if (wr_merge) mix[wr_off] = wr_word;
  end

  // Only valid bits are reset; tag/data are don't-care until installed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= mix;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_block = data[rd_idx];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-through/write-allocate L1 D-cache: FSM plus registered
// CPU and L2 interfaces around l1_line_store.
module l1_dcache
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_LINES   = 16,
  parameter int BLOCK_WORDS = 16
)(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ADDR_WIDTH-1:0]             cpu_addr,
  input  logic [DATA_WIDTH-1:0]             cpu_wdata,
  input  logic                              cpu_read,
  input  logic                              cpu_write,
  output logic [DATA_WIDTH-1:0]             cpu_rdata,
  output logic                              cpu_ready,
  output logic                              cpu_hit,
  output logic [ADDR_WIDTH-1:0]             l2_addr,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] l2_data_out,
  output logic                              l2_read,
  output logic                              l2_write,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] l2_block_in,
  input  logic                              l2_block_valid,
  input  logic                              l2_ready
);

  localparam int OFS_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TG_W  = ADDR_WIDTH - OFS_W - IDX_W;

  typedef logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] blk_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_wr;
  logic                  lk_vld;
  logic                  hit_r;
  blk_t                  line_r;
  blk_t                  dout;

  logic [OFS_W-1:0]      off;
  logic [IDX_W-1:0]      idx;
  logic [TG_W-1:0]       tag;
  logic [ADDR_WIDTH-1:0] blk_addr;
  logic                  rd_valid;
  logic [TG_W-1:0]       rd_tag;
  blk_t                  rd_block, blk_in, src_blk, merged;
  logic                  fill_done, wr_en;

  assign off      = req_addr[OFS_W-1:0];
  assign idx      = req_addr[OFS_W +: IDX_W];
  assign tag      = req_addr[ADDR_WIDTH-1 -: TG_W];
  assign blk_addr = {req_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
  assign blk_in   = l2_block_in;
  assign l2_data_out = dout;

  assign fill_done = (state == FILL) && l2_ready && l2_block_valid;
  assign src_blk   = (state == FILL) ? blk_in : line_r;
  assign wr_en     = fill_done || (state == LOOKUP && lk_vld && hit_r && req_wr);

  // Merged block feeds the write-through; the store applies the same overlay.
  always_comb begin
    merged = src_blk;
    if (req_wr) merged[off] = req_wdata;
  end

  l1_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_LINES  (NUM_LINES),
    .BLOCK_WORDS(BLOCK_WORDS),
    .IDX_BITS   (IDX_W),
    .OFF_BITS   (OFS_W),
    .TAG_BITS   (TG_W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_block(rd_block),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_tag  (tag),
    .wr_block(src_blk),
    .wr_merge(req_wr),
    .wr_off  (off),
    .wr_word (req_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // LOOKUP spends one cycle registering the tag compare, then acts on it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cpu_read || cpu_write) state_nx = LOOKUP;
      LOOKUP:  if (lk_vld) state_nx = !hit_r ? FILL : (req_wr ? WTHRU : IDLE);
      FILL:    if (fill_done) state_nx = req_wr ? WTHRU : IDLE;
      WTHRU:   if (l2_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wr    <= 1'b0;
      lk_vld    <= 1'b0;
      hit_r     <= 1'b0;
      line_r    <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      l2_addr   <= '0;
      dout      <= '0;
      l2_read   <= 1'b0;
      l2_write  <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: if (cpu_read || cpu_write) begin
          req_addr  <= cpu_addr;
          req_wdata <= cpu_wdata;
          req_wr    <= cpu_write;
          lk_vld    <= 1'b0;
        end
        LOOKUP: begin
          if (!lk_vld) begin
            lk_vld <= 1'b1;
            hit_r  <= rd_valid && (rd_tag == tag);
            line_r <= rd_block;
          end else if (hit_r && !req_wr) begin
            cpu_rdata <= line_r[off];
            cpu_ready <= 1'b1;
            cpu_hit   <= 1'b1;
          end else begin
            l2_addr <= blk_addr;
            if (hit_r) begin
              dout     <= merged;
              l2_write <= 1'b1;
            end else begin
              l2_read  <= 1'b1;
            end
          end
        end
        FILL: if (fill_done) begin
          l2_read <= 1'b0;
          if (req_wr) begin
            dout     <= merged;
            l2_write <= 1'b1;
          end else begin
            l2_addr   <= '0;
            cpu_rdata <= blk_in[off];
            cpu_ready <= 1'b1;
            cpu_hit   <= 1'b0;
          end
        end
        WTHRU: if (l2_ready) begin
          l2_write  <= 1'b0;
          l2_addr   <= '0;
          dout      <= '0;
          cpu_ready <= 1'b1;
          cpu_hit   <= hit_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-through, write-allocate L1 data cache between the CPU load/store port and the L2 cache. Serves single-word CPU reads and writes from a local line store. Fetches whole blocks from L2 on a miss. Pushes every write to L2 as a full merged block. One CPU request is outstanding at a time.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 32, word address width
- NUM_LINES, 16, number of lines (power of 2)
- BLOCK_WORDS, 16, words per block (power of 2); must equal the L2 block size
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_rdata  out  DATA_WIDTH  load data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_hit  out  1  request hit, qualified by cpu_ready
- l2_addr  out  ADDR_WIDTH  block-aligned address (offset bits 0)
- l2_data_out  out  BLOCK_WORDS*DATA_WIDTH  write-through block
- l2_read  out  1  block fetch request
- l2_write  out  1  block write request
- l2_block_in  in  BLOCK_WORDS*DATA_WIDTH  fetched block
- l2_block_valid  in  1  l2_block_in valid
- l2_ready  in  1  L2 completion

## Operation
- Address split: offset = low log2(BLOCK_WORDS) bits; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Per-line storage: valid, tag, block.
- FSM states: IDLE, LOOKUP, FILL, WTHRU.
- IDLE: on cpu_read or cpu_write, latch addr, wdata and op, then go to LOOKUP. If both are high, the request is a write. Requests seen outside IDLE are ignored; the CPU holds them until cpu_ready.
- LOOKUP, read hit: register word[offset] into cpu_rdata, pulse cpu_ready with cpu_hit=1, go to IDLE.
- LOOKUP, write hit: merge wdata into the line at offset, load the merged block into l2_data_out, go to WTHRU.
- LOOKUP, any miss: set l2_addr = {tag,index,0}, raise l2_read, go to FILL.
- FILL: when l2_ready=1 and l2_block_valid=1, install the block (overwrite, no eviction write-back), set valid and tag.
  - Read: return word[offset], pulse cpu_ready with cpu_hit=0, go to IDLE.
  - Write: merge wdata, load l2_data_out, go to WTHRU.
  - l2_ready=1 with l2_block_valid=0 is ignored; the request stays up.
- WTHRU: l2_write=1, l2_read=0. On l2_ready, pulse cpu_ready (cpu_hit reflects the LOOKUP result), go to IDLE.
- A write hit and a write miss produce identical L2 traffic apart from the preceding fill.

## Timing
- Reset values: all valid bits 0, state IDLE, cpu_ready 0, cpu_hit 0, cpu_rdata 0, l2_read 0, l2_write 0, l2_addr 0, l2_data_out 0.
- All outputs are registered.
- Read hit: request sampled at edge 0, cpu_ready high in the cycle after edge 2 (2-cycle latency).
- Miss: l2_read rises after edge 2. l2_read, l2_addr and l2_data_out stay stable until the edge that samples l2_ready=1, and drop after that edge. cpu_ready follows one cycle after the fill.
- Write: cpu_ready follows one cycle after the edge that samples l2_ready in WTHRU.
- cpu_ready is never high for two consecutive cycles. The earliest next request is sampled in the cycle cpu_ready is high.
- Reset mid-operation: the transaction is aborted, all lines are invalidated, L2 requests drop immediately, and no cpu_ready is issued.
- A tag match on a line with valid=0 is a miss.

## Structure
- Package l1_cache_pkg holds: the state enum, derived widths (OFFSET_W, INDEX_W, TAG_W), and a block_t packed type.
- Sub-module l1_line_store holds valid, tag and data arrays. It has one combinational read port (by index) and one write port with word-merge enable. Reset clears the valid bits only.
- Top level holds the FSM and the L2/CPU registers.

## Test plan
- Cold read 0x0000_0045: l2_read with l2_addr 0x40; return block words i = 0x100+i; cpu_rdata 0x105 with cpu_hit=0. Re-read 0x45: cpu_hit=1, 0x105, no l2_read.
- Write 0xDEAD_BEEF to 0x45 after the fill: l2_write, l2_data_out word5 = 0xDEADBEEF, other words 0x100+i; a later read of 0x45 returns 0xDEADBEEF as a hit.
- Conflict: read 0x45, then 0x145 (same index, new tag), then 0x45; each is a miss and the third triggers a new fill.
- L2 stalls 10 cycles, with l2_ready=1 and l2_block_valid=0 once mid-stall: l2_read and l2_addr stay stable, no install, single cpu_ready at the end.
- Assert rst_n low during FILL: l2_read drops at once, no cpu_ready; a read of the same address after reset misses.
- cpu_read and cpu_write both high on 0x10: treated as a write, l2_write occurs, no read-data response.
